// File: rtl/cond_eval_unit.sv
// Condition evaluation unit: architectural NZV flag register, 4-bit condition decode,
// registered take/illegal result over a valid/ready handshake, overflow statistics.
module cond_eval_unit #(
    parameter bit          BYPASS    = 1'b1,
    parameter int unsigned OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 zero_in,
    input  logic                 overflow_in,
    input  logic                 sign_in,
    input  logic                 flags_we,
    input  logic                 cond_valid,
    input  logic [3:0]           cond_code,
    output logic                 cond_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_take,
    output logic                 out_illegal,
    input  logic                 flush,
    input  logic                 clr_stats,
    output logic [2:0]           flags_q,
    output logic                 ovf_sticky,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    logic [2:0] eval_flags;
    logic       n_f, z_f, v_f;
    logic       take_d;
    logic       illegal_d;
    logic       accept;

    // Select the flags the condition is evaluated against and decode the condition.
    always_comb begin
        eval_flags = (BYPASS && flags_we) ? {sign_in, zero_in, overflow_in} : flags_q;
        n_f        = eval_flags[2];
        z_f        = eval_flags[1];
        v_f        = eval_flags[0];
        take_d     = 1'b0;
        illegal_d  = 1'b0;
        case (cond_code)
            4'd0:    take_d = z_f;
            4'd1:    take_d = !z_f;
            4'd2:    take_d = n_f ^ v_f;
            4'd3:    take_d = !(n_f ^ v_f);
            4'd4:    take_d = !z_f && !(n_f ^ v_f);
            4'd5:    take_d = z_f || (n_f ^ v_f);
            4'd6:    take_d = v_f;
            4'd7:    take_d = !v_f;
            4'd8:    take_d = n_f;
            4'd9:    take_d = !n_f;
            4'd10:   take_d = 1'b1;
            default: illegal_d = 1'b1;
        endcase
    end

    // Input side may accept whenever the output slot is empty or being drained.
    always_comb begin
        cond_ready = !out_valid || out_ready;
        accept     = cond_valid && cond_ready && !flush;
    end

    // Architectural flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else if (flags_we) begin
            flags_q <= {sign_in, zero_in, overflow_in};
        end
    end

    // Result slot: flush drops it, an accepted query refills it, consumption empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_take    <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_take    <= take_d;
            out_illegal <= illegal_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Overflow statistics; clear takes priority over a same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (clr_stats) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (flags_we && overflow_in) begin
            ovf_sticky <= 1'b1;
            if (ovf_count != {OVF_CNT_W{1'b1}}) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cond_eval_unit.sv
// Self-checking bench for cond_eval_unit: two instances (bypass/8-bit counter and
// no-bypass/2-bit counter) share stimulus and are checked against a behavioural model.
module tb_cond_eval_unit;

    logic       clk;
    logic       rst_n;
    logic       zero_in, overflow_in, sign_in, flags_we;
    logic       cond_valid;
    logic [3:0] cond_code;
    logic       out_ready, flush, clr_stats;

    logic       cond_ready_w [2];
    logic       out_valid_w  [2];
    logic       out_take_w   [2];
    logic       out_illegal_w[2];
    logic [2:0] flags_w      [2];
    logic       sticky_w     [2];
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int total = 0;
    int bad   = 0;

    // Model state per instance
    bit m_bypass[2] = '{1'b1, 1'b0};
    int m_cmax  [2] = '{255, 3};
    bit [2:0] m_flags[2];
    bit m_valid[2], m_take[2], m_ill[2], m_sticky[2];
    int m_cnt[2];

    cond_eval_unit #(.BYPASS(1'b1), .OVF_CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .zero_in(zero_in), .overflow_in(overflow_in),
        .sign_in(sign_in), .flags_we(flags_we), .cond_valid(cond_valid),
        .cond_code(cond_code), .cond_ready(cond_ready_w[0]), .out_valid(out_valid_w[0]),
        .out_ready(out_ready), .out_take(out_take_w[0]), .out_illegal(out_illegal_w[0]),
        .flush(flush), .clr_stats(clr_stats), .flags_q(flags_w[0]),
        .ovf_sticky(sticky_w[0]), .ovf_count(cnt0)
    );

    cond_eval_unit #(.BYPASS(1'b0), .OVF_CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .zero_in(zero_in), .overflow_in(overflow_in),
        .sign_in(sign_in), .flags_we(flags_we), .cond_valid(cond_valid),
        .cond_code(cond_code), .cond_ready(cond_ready_w[1]), .out_valid(out_valid_w[1]),
        .out_ready(out_ready), .out_take(out_take_w[1]), .out_illegal(out_illegal_w[1]),
        .flush(flush), .clr_stats(clr_stats), .flags_q(flags_w[1]),
        .ovf_sticky(sticky_w[1]), .ovf_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit [2:0] nzv;
        bit [3:0] code;
        bit       take;
        bit       ill;
    } vec_t;

    vec_t vecs[17];

    function automatic int count_of(int i);
        return (i == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Condition truth from the architectural definitions.
    function automatic bit cond_true(bit [3:0] code, bit [2:0] f);
        bit n, z, v;
        n = f[2]; z = f[1]; v = f[0];
        case (code)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return n != v;
            4'd3:    return n == v;
            4'd4:    return !z && (n == v);
            4'd5:    return z || (n != v);
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return n;
            4'd9:    return !n;
            4'd10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_flags[i] = 3'b000; m_valid[i] = 0; m_take[i] = 0; m_ill[i] = 0;
            m_sticky[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic clear_inputs();
        zero_in = 0; overflow_in = 0; sign_in = 0; flags_we = 0; cond_valid = 0;
        cond_code = 4'd0; out_ready = 1; flush = 0; clr_stats = 0;
    endtask

    task automatic set_flags_in(bit [2:0] nzv);
        sign_in = nzv[2]; zero_in = nzv[1]; overflow_in = nzv[0];
    endtask

    // Check current outputs against the model, then advance one clock.
    task automatic cycle();
        bit [2:0] f;
        bit       rdy;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.out_valid", i), out_valid_w[i], m_valid[i]);
            if (m_valid[i]) begin
                chk($sformatf("u%0d.out_take", i), out_take_w[i], m_take[i]);
                chk($sformatf("u%0d.out_illegal", i), out_illegal_w[i], m_ill[i]);
            end
            chk($sformatf("u%0d.cond_ready", i), cond_ready_w[i], !m_valid[i] || out_ready);
            chk($sformatf("u%0d.flags_q", i), flags_w[i], m_flags[i]);
            chk($sformatf("u%0d.ovf_sticky", i), sticky_w[i], m_sticky[i]);
            chk($sformatf("u%0d.ovf_count", i), count_of(i), m_cnt[i]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            f   = (m_bypass[i] && flags_we) ? {sign_in, zero_in, overflow_in} : m_flags[i];
            rdy = !m_valid[i] || out_ready;
            if (flush) begin
                m_valid[i] = 0;
            end else if (cond_valid && rdy) begin
                m_valid[i] = 1;
                m_take[i]  = cond_true(cond_code, f);
                m_ill[i]   = (cond_code > 4'd10);
            end else if (out_ready) begin
                m_valid[i] = 0;
            end
            if (flags_we) m_flags[i] = {sign_in, zero_in, overflow_in};
            if (clr_stats) begin
                m_sticky[i] = 0; m_cnt[i] = 0;
            end else if (flags_we && overflow_in) begin
                m_sticky[i] = 1;
                if (m_cnt[i] < m_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{3'b010, 4'd0,  1'b1, 1'b0};
        vecs[1]  = '{3'b000, 4'd0,  1'b0, 1'b0};
        vecs[2]  = '{3'b000, 4'd1,  1'b1, 1'b0};
        vecs[3]  = '{3'b100, 4'd2,  1'b1, 1'b0};
        vecs[4]  = '{3'b101, 4'd2,  1'b0, 1'b0};
        vecs[5]  = '{3'b101, 4'd3,  1'b1, 1'b0};
        vecs[6]  = '{3'b000, 4'd4,  1'b1, 1'b0};
        vecs[7]  = '{3'b001, 4'd4,  1'b0, 1'b0};
        vecs[8]  = '{3'b110, 4'd4,  1'b0, 1'b0};
        vecs[9]  = '{3'b010, 4'd5,  1'b1, 1'b0};
        vecs[10] = '{3'b001, 4'd6,  1'b1, 1'b0};
        vecs[11] = '{3'b001, 4'd7,  1'b0, 1'b0};
        vecs[12] = '{3'b100, 4'd8,  1'b1, 1'b0};
        vecs[13] = '{3'b100, 4'd9,  1'b0, 1'b0};
        vecs[14] = '{3'b000, 4'd10, 1'b1, 1'b0};
        vecs[15] = '{3'b111, 4'd11, 1'b0, 1'b1};
        vecs[16] = '{3'b111, 4'd15, 1'b0, 1'b1};

        // Reset with random inputs: every output held at zero
        rst_n = 0;
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            {zero_in, overflow_in, sign_in, flags_we} = 4'($urandom);
            {cond_valid, out_ready, flush, clr_stats} = 4'($urandom);
            cond_code = 4'($urandom);
            #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rst u%0d.out_valid", i), out_valid_w[i], 0);
                chk($sformatf("rst u%0d.out_take", i), out_take_w[i], 0);
                chk($sformatf("rst u%0d.out_illegal", i), out_illegal_w[i], 0);
                chk($sformatf("rst u%0d.flags_q", i), flags_w[i], 0);
                chk($sformatf("rst u%0d.ovf_sticky", i), sticky_w[i], 0);
                chk($sformatf("rst u%0d.ovf_count", i), count_of(i), 0);
            end
        end
        clear_inputs();
        #1;
        rst_n = 1;
        model_reset();

        // First query after reset: AL taken one cycle later
        cond_valid = 1; cond_code = 4'd10;
        cycle();
        clear_inputs();
        #1;
        chk("post-rst valid", out_valid_w[0], 1);
        chk("post-rst take", out_take_w[0], 1);
        cycle();

        // Constant vector table
        foreach (vecs[k]) begin
            flags_we = 1; set_flags_in(vecs[k].nzv);
            cycle();
            clear_inputs();
            cond_valid = 1; cond_code = vecs[k].code;
            cycle();
            clear_inputs();
            #1;
            chk($sformatf("vec%0d take", k), out_take_w[0], vecs[k].take);
            chk($sformatf("vec%0d illegal", k), out_illegal_w[0], vecs[k].ill);
            cycle();
        end

        // Full sweep, back-to-back queries
        for (int f = 0; f < 8; f++) begin
            flags_we = 1; set_flags_in(3'(f));
            cycle();
            clear_inputs();
            for (int c = 0; c < 16; c++) begin
                cond_valid = 1; cond_code = 4'(c);
                cycle();
            end
            clear_inputs();
            cycle();
        end

        // Bypass: same-cycle write of Z=1 with EQ query
        flags_we = 1; set_flags_in(3'b000);
        cycle();
        clear_inputs();
        flags_we = 1; set_flags_in(3'b010); cond_valid = 1; cond_code = 4'd0;
        cycle();
        clear_inputs();
        #1;
        chk("bypass1 take", out_take_w[0], 1);
        chk("bypass0 take", out_take_w[1], 0);
        cycle();

        // Backpressure: AL result held while a VS query (V=0) waits
        flags_we = 1; set_flags_in(3'b000);
        cycle();
        clear_inputs();
        cond_valid = 1; cond_code = 4'd10;
        cycle();
        out_ready = 0; cond_code = 4'd6;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp cond_ready", cond_ready_w[0], 0);
            chk("bp hold take", out_take_w[0], 1);
            chk("bp hold valid", out_valid_w[0], 1);
        end
        out_ready = 1;
        cycle();
        cond_valid = 0;
        #1;
        chk("bp next valid", out_valid_w[0], 1);
        chk("bp next take", out_take_w[0], 0);
        cycle();
        #1;
        chk("bp drained", out_valid_w[0], 0);
        cycle();

        // Flush with an overflow flag write
        clr_stats = 1;
        cycle();
        clear_inputs();
        cond_valid = 1; cond_code = 4'd10; out_ready = 0;
        cycle();
        flush = 1; flags_we = 1; set_flags_in(3'b001);
        cycle();
        clear_inputs();
        #1;
        chk("flush valid", out_valid_w[0], 0);
        chk("flush sticky", sticky_w[0], 1);
        chk("flush count", count_of(0), 1);
        cycle();

        // Counter saturation and clear priority
        clr_stats = 1;
        cycle();
        clear_inputs();
        flags_we = 1; set_flags_in(3'b001);
        for (int k = 0; k < 5; k++) cycle();
        clear_inputs();
        #1;
        chk("sat w2 count", count_of(1), 3);
        chk("sat w8 count", count_of(0), 5);
        clr_stats = 1; flags_we = 1; set_flags_in(3'b001);
        cycle();
        clear_inputs();
        #1;
        chk("clr w2 count", count_of(1), 0);
        chk("clr sticky", sticky_w[1], 0);
        cycle();

        // Asynchronous reset with a pending result
        cond_valid = 1; cond_code = 4'd10; out_ready = 0;
        cycle();
        clear_inputs();
        #2;
        rst_n = 0;
        #1;
        chk("async rst valid0", out_valid_w[0], 0);
        chk("async rst valid1", out_valid_w[1], 0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1;
        cycle();

        // Randomized traffic against the model
        for (int k = 0; k < 2000; k++) begin
            {zero_in, overflow_in, sign_in} = 3'($urandom);
            flags_we   = 1'($urandom);
            cond_valid = ($urandom_range(0, 3) != 0);
            cond_code  = 4'($urandom);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            clr_stats  = ($urandom_range(0, 31) == 0);
            cycle();
        end
        clear_inputs();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
